// File: rtl/jtcop_pal_arb_if.sv
// CPU-side palette bus between the address decoder and the palette arbiter.
// The CPU holds cpu_cs until it sees cpu_ok.
interface jtcop_pal_arb_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic          cpu_cs;
    logic          cpu_rnw;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic [1:0]    dsn;
    logic [DW-1:0] cpu_din;
    logic          cpu_ok;

    modport master (
        output cpu_cs,
        output cpu_rnw,
        output cpu_addr,
        output cpu_dout,
        output dsn,
        input  cpu_din,
        input  cpu_ok
    );

    modport slave (
        input  cpu_cs,
        input  cpu_rnw,
        input  cpu_addr,
        input  cpu_dout,
        input  dsn,
        output cpu_din,
        output cpu_ok
    );
endinterface

// File: rtl/jtcop_pal_arb.sv
// Time-shares a single-port palette RAM between video pixel reads
// and CPU accesses, with a bounded CPU wait before a slot is stolen.
module jtcop_pal_arb #(
    parameter int AW     = 10,
    parameter int DW     = 16,
    parameter int STARVE = 15
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic          LVBL,
    jtcop_pal_arb_if.slave cpu,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic [1:0]    ram_we,
    input  logic [DW-1:0] ram_q
);
    localparam logic [3:0] STV = 4'(STARVE);

    typedef enum logic [2:0] {
        IDLE, PEND, ISSUE, RDWAIT, ACK
    } st_t;

    st_t           st_q, st_d;
    logic          cs_q, rise_q;
    logic [3:0]    cnt_q, cnt_d;
    logic          rnw_q, rnw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [1:0]    dsn_q, dsn_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_data_q, ram_data_d;
    logic [1:0]    ram_we_q, ram_we_d;
    logic [DW-1:0] din_q, din_d;
    logic          ok_q, ok_d;
    logic [DW-1:0] vid_data_q, vid_data_d;
    logic [1:0]    vp_q;

    logic vslot, steal, go, vtake;

    assign vslot = pxl_cen & LHBL & LVBL;
    assign steal = (cnt_q == STV);
    assign go    = (st_q == PEND) & (~vslot | steal);
    assign vtake = vslot & ~go;

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        dsn_d      = dsn_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 2'b00;
        din_d      = din_q;
        vid_data_d = vid_data_q;

        if (vtake) ram_addr_d = vid_addr;
        if (vp_q[1]) vid_data_d = ram_q;

        // Request fields are frozen on the raw cs edge so a cs
        // dropped before ack still completes with the right data.
        if (st_q == IDLE && cpu.cpu_cs && !cs_q) begin
            rnw_d  = cpu.cpu_rnw;
            addr_d = cpu.cpu_addr;
            dout_d = cpu.cpu_dout;
            dsn_d  = cpu.dsn;
        end

        unique case (st_q)
            IDLE: begin
                if (rise_q) st_d = PEND;
            end
            PEND: begin
                if (go) begin
                    st_d       = ISSUE;
                    cnt_d      = 4'd0;
                    ram_addr_d = addr_q;
                    ram_data_d = dout_q;
                    ram_we_d   = rnw_q ? 2'b00 : ~dsn_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ISSUE: begin
                st_d = rnw_q ? RDWAIT : ACK;
            end
            RDWAIT: begin
                din_d = ram_q;
                st_d  = ACK;
            end
            ACK: begin
                if (!cpu.cpu_cs) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase

        ok_d = (st_d == ACK);
    end

    // cs_q resets high so a cs held through reset is not a new edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= IDLE;
            cs_q       <= 1'b1;
            rise_q     <= 1'b0;
            cnt_q      <= 4'd0;
            rnw_q      <= 1'b1;
            addr_q     <= '0;
            dout_q     <= '0;
            dsn_q      <= 2'b11;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 2'b00;
            din_q      <= '0;
            ok_q       <= 1'b0;
            vid_data_q <= '0;
            vp_q       <= 2'b00;
        end else begin
            st_q       <= st_d;
            cs_q       <= cpu.cpu_cs;
            rise_q     <= cpu.cpu_cs & ~cs_q;
            cnt_q      <= cnt_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            dsn_q      <= dsn_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            din_q      <= din_d;
            ok_q       <= ok_d;
            vid_data_q <= vid_data_d;
            vp_q       <= {vp_q[0], vtake};
        end
    end

    assign cpu.cpu_din = din_q;
    assign cpu.cpu_ok  = ok_q;
    assign vid_data    = vid_data_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data    = ram_data_q;
    assign ram_we      = ram_we_q;
endmodule

// File: doc/jtcop_pal_arb.md
Name: jtcop_pal_arb

Overview:
- Time-shares one single-port palette RAM between the 68000-side CPU bus and the colour-mixer video read path.
- Allows the palette to sit in a single-port block instead of a dual-port one.
- Video reads are served on pixel slots during active display; CPU reads and writes are served in free slots, with a bounded wait.
- Sits between the CPU address decoder, the colour-mix palette-address stage and the palette RAM. Single clock domain (clk).

Parameters:
- AW, 10, palette RAM address width.
- DW, 16, data width; byte enables cover DW/8 = 2 lanes.
- STARVE, 15, maximum clk cycles a pending CPU access waits before it steals a video slot (4-bit counter; legal range 1–15).

Ports:
- rst  in  1  asynchronous reset, active high
- clk  in  1  system clock; all logic on its rising edge
- pxl_cen  in  1  pixel clock enable; marks a video slot
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- cpu_cs  in  1  CPU palette access request, level; held until cpu_ok is seen
- cpu_rnw  in  1  1 = read, 0 = write; stable while cpu_cs is high
- cpu_addr  in  AW  CPU word address
- cpu_dout  in  DW  CPU write data
- dsn  in  2  byte strobes, active low; [1] = upper byte
- cpu_din  out  DW  CPU read data, valid while cpu_ok is high
- cpu_ok  out  1  access-complete acknowledge
- vid_addr  in  AW  video palette address, sampled on video slots
- vid_data  out  DW  video palette data
- ram_addr  out  AW  RAM address
- ram_data  out  DW  RAM write data
- ram_we  out  2  RAM byte write enables, active high
- ram_q  in  DW  RAM read data; synchronous, 1 clk latency

Behaviour:
- Reset values:
  - cpu_din=0, cpu_ok=0, vid_data=0, ram_addr=0, ram_data=0, ram_we=0.
  - Starvation counter = 0; FSM = IDLE.
  - Asserting rst mid-access aborts it immediately. No write is issued after rst rises. cpu_ok stays low until the next fresh cs edge after rst falls.
- Slot classification, per clk:
  - Video slot: pxl_cen & LHBL & LVBL.
  - Every other cycle is a free slot.
  - During blanking every cycle is free.
- Video path:
  - On a video slot not stolen by the CPU: ram_addr <= vid_addr, ram_we <= 0.
  - vid_data <= ram_q exactly two clk cycles after that slot.
  - Total latency: vid_addr to vid_data = 2 clk.
  - On stolen or blanking slots, vid_data holds its last value.
- CPU request capture:
  - A request is accepted on the rising edge of cpu_cs (registered edge detect).
  - A cs held high after acknowledge never triggers a second access.
- FSM states: IDLE, PEND, ISSUE, RDWAIT, ACK.
  - IDLE → PEND on cs rise.
  - PEND → ISSUE when either condition holds:
    - the current cycle is a free slot, or
    - the starvation counter equals STARVE (steal).
  - ISSUE drives the RAM for one cycle:
    - ram_addr <= cpu_addr, ram_data <= cpu_dout.
    - ram_we <= ~dsn if cpu_rnw=0, otherwise 0.
  - ISSUE → ACK for a write; ISSUE → RDWAIT for a read.
  - RDWAIT: cpu_din <= ram_q; → ACK.
  - ACK: cpu_ok = 1; stays until cpu_cs = 0, then cpu_ok <= 0 and → IDLE.
- Latency from cs edge with a free slot available:
  - Write: cpu_ok high 3 clk after the registered edge.
  - Read: cpu_ok high 4 clk after the registered edge.
- Starvation counter:
  - Increments each cycle in PEND on which a video slot is denied to the CPU; saturates at STARVE.
  - Clears on leaving PEND.
- Simultaneous video slot and CPU ISSUE: the CPU wins only via steal. Otherwise the video slot wins and the CPU stays in PEND.
- dsn = 2'b11 on a write: the access completes and acks, but ram_we stays 0.
- cpu_cs falling before ack:
  - The access still completes.
  - cpu_ok pulses for exactly 1 clk.
  - The FSM then returns to IDLE.
- Address wrap: none. Addresses are used as given, width AW.

Test Plan:
- Reset: hold rst with cpu_cs=1 → all outputs 0; after release, no access occurs until cs goes low then high.
- Blanking write: LVBL=0, write addr 0x123, data 0xA5C3, dsn=2'b01 → ram_we=2'b10 for one cycle with ram_addr=0x123; cpu_ok high 3 clk after the edge.
- Video read: pxl_cen every 4th clk, vid_addr=0x045, RAM preloaded with 0x0F0F → vid_data=0x0F0F two clk after the slot; a CPU read interleaved in free slots returns its own correct word.
- Starvation: pxl_cen=1 continuously during active video, CPU read pending → steal after 15 waited cycles; vid_data holds its previous value during the stolen slot; CPU read data is correct.
- Early cs drop: write with cpu_cs low 1 clk after the edge → RAM still written; cpu_ok single-cycle pulse; FSM back in IDLE.
- Reset mid-access: rst asserted while in PEND for a write → no ram_we pulse ever issued; RAM contents unchanged.
